ahbext_sram_ctrl: RTL and testbench
===================================

Name: ahbext_sram_ctrl

Overview:
AHB-Lite subordinate controller that sits on the SoC external AHB port (HSELEXT / HREADYEXT / HRESPEXT / HRDATAEXT) and sequences accesses to a single-port synchronous SRAM with a programmable number of wait states. It replaces the tied-off external responder in simulation and lint builds. It decodes and range-checks each transfer, inserts wait states, drives the SRAM strobes and returns OKAY or ERROR responses.

Parameters:
AHBW, 64, AHB data width in bits (32 or 64)
PA_BITS, 34, physical address width
BASE, 34'h0_9000_0000, first byte address served
MEMWORDS, 4096, SRAM depth in AHBW-bit words
WAITSTATES, 2, extra data-phase cycles before the SRAM access (0..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
HSELEXT  in  1  external port select
HADDR  in  PA_BITS  address-phase address
HTRANS  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ)
HWRITE  in  1  address-phase write flag
HSIZE  in  3  address-phase transfer size
HREADY  in  1  bus-wide ready; address phase is accepted only when it is high
HWDATA  in  AHBW  data-phase write data
HWSTRB  in  AHBW/8  data-phase byte strobes
HRDATAEXT  out  AHBW  read data
HREADYEXT  out  1  data-phase ready
HRESPEXT  out  1  data-phase error response
MemEn  out  1  SRAM enable
MemWE  out  1  SRAM write enable
MemAdr  out  $clog2(MEMWORDS)  SRAM word address
MemWData  out  AHBW  SRAM write data
MemBE  out  AHBW/8  SRAM byte enables
MemRData  in  AHBW  SRAM read data, valid the cycle after MemEn (registered output)

Behaviour:
- Reset (asynchronous, active-high): state IDLE, wait counter 0, HREADYEXT=1, HRESPEXT=0, HRDATAEXT=0, MemEn=0, MemWE=0, MemBE=0. An in-flight write is aborted and MemWE is never asserted for it.
- Accept: an address phase is accepted on a rising edge where HSELEXT & HREADY & HTRANS[1] are all high. On accept, register HWRITE, the word address and the error flag.
- Error condition: (HADDR-BASE) >= MEMWORDS*AHBW/8, or HADDR<BASE, or HSIZE > log2(AHBW/8).
- Non-accepted address phases (HSELEXT low, or HTRANS IDLE/BUSY): no state change; if selected, a zero-wait OKAY is returned.
- MemAdr = (HADDR-BASE) >> log2(AHBW/8), truncated to the MemAdr width.
- States:
  - IDLE: HREADYEXT=1; stay until accept; then go to WAIT, or to ERR1 if the error flag is set.
  - WAIT: data-phase cycle counter k runs from 0. HREADYEXT=0 while k<WAITSTATES.
    - At k=WAITSTATES, write: MemEn=MemWE=1, MemWData=HWDATA, MemBE=HWSTRB, HREADYEXT=1. This completes the write (WAITSTATES+1 data-phase cycles).
    - At k=WAITSTATES, read: MemEn=1, MemWE=0, HREADYEXT=0; go to RDATA.
  - RDATA: HREADYEXT=1, HRDATAEXT=MemRData. A read takes WAITSTATES+2 data-phase cycles. HRDATAEXT=0 in every other cycle.
  - ERR1: HRESPEXT=1, HREADYEXT=0; go to ERR2.
  - ERR2: HRESPEXT=1, HREADYEXT=1; no SRAM access.
- Completion exit: from every completing cycle (write at k=WAITSTATES, RDATA, ERR2), a simultaneous new accept goes to WAIT or ERR1 (back-to-back, no bubble); otherwise go to IDLE.
- WAITSTATES=0: write finishes in 1 cycle, read in 2.
- The counter resets to 0 on every accept. It is 4 bits wide and never wraps because it saturates at WAITSTATES.
- HWDATA/HWSTRB are sampled only in the MemWE cycle.
- HSELEXT dropping during a data phase does not abort the transfer.
- MemWE is never high without MemEn; MemEn is high for exactly one cycle per valid transfer.

Test Plan:
- WAITSTATES=2, write 64'hDEADBEEF_01234567 to BASE+8, full strobes -> HREADYEXT low 2 cycles; MemWE high 1 cycle with MemAdr=1, MemBE=8'hFF.
- Read BASE+8 after that write -> HREADYEXT low 3 cycles, then high with HRDATAEXT=64'hDEADBEEF_01234567, HRESPEXT=0.
- Back-to-back NONSEQ write BASE then read BASE+0x10 -> second address accepted in the write's completion cycle; MemAdr 0 then 2; no idle cycle between.
- Read BASE+MEMWORDS*8, and a 64-bit aligned access with HSIZE=3'b100 -> two-cycle ERROR: (HREADYEXT,HRESPEXT)=(0,1) then (1,1); MemEn stays 0.
- Byte write HWSTRB=8'h10 at BASE+4 -> MemBE=8'h10; a read of the same word returns only byte 4 changed.
- Assert reset during WAIT of a write, k=1 -> MemWE never asserts; HREADYEXT=1, HRESPEXT=0 immediately; the next access completes normally.

Source files
------------

// File: rtl/ahbext_sram_ctrl.sv
// AHB-Lite subordinate on the SoC external port: decodes and range-checks each
// transfer, inserts WAITSTATES data-phase cycles and drives a single-port SRAM.
module ahbext_sram_ctrl #(
    parameter int unsigned          AHBW       = 64,
    parameter int unsigned          PA_BITS    = 34,
    parameter logic [PA_BITS-1:0]   BASE       = 34'h0_9000_0000,
    parameter int unsigned          MEMWORDS   = 4096,
    parameter int unsigned          WAITSTATES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          HSELEXT,
    input  logic [PA_BITS-1:0]            HADDR,
    input  logic [1:0]                    HTRANS,
    input  logic                          HWRITE,
    input  logic [2:0]                    HSIZE,
    input  logic                          HREADY,
    input  logic [AHBW-1:0]               HWDATA,
    input  logic [AHBW/8-1:0]             HWSTRB,
    output logic [AHBW-1:0]               HRDATAEXT,
    output logic                          HREADYEXT,
    output logic                          HRESPEXT,
    output logic                          MemEn,
    output logic                          MemWE,
    output logic [$clog2(MEMWORDS)-1:0]   MemAdr,
    output logic [AHBW-1:0]               MemWData,
    output logic [AHBW/8-1:0]             MemBE,
    input  logic [AHBW-1:0]               MemRData
);

    localparam int unsigned BYTES    = AHBW / 8;
    localparam int unsigned OFF_BITS = $clog2(BYTES);
    localparam int unsigned ADR_W    = $clog2(MEMWORDS);
    localparam int unsigned SPAN     = MEMWORDS * BYTES;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RDATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_write;
    logic [ADR_W-1:0]   r_adr;

    logic [PA_BITS-1:0] w_off;
    logic               w_err;
    logic [ADR_W-1:0]   w_word;
    logic               w_last;
    logic               w_done;
    logic               w_accept;
    logic               w_take;

    // Address-phase decode and range check
    assign w_off    = HADDR - BASE;
    assign w_err    = (HADDR < BASE) | (w_off >= PA_BITS'(SPAN)) | (HSIZE > 3'(OFF_BITS));
    assign w_word   = ADR_W'(w_off >> OFF_BITS);

    assign w_last   = (r_cnt == CNT_W'(WAITSTATES));
    assign w_done   = ((r_state == S_WAIT) && w_last && r_write)
                    || (r_state == S_RDATA) || (r_state == S_ERR2);
    assign w_accept = HSELEXT & HREADY & HTRANS[1];
    // A new address phase is taken when idle or in the completing cycle (no bubble)
    assign w_take   = w_accept & ((r_state == S_IDLE) | w_done);

    assign MemAdr   = r_adr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_adr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_take) begin
                r_write <= HWRITE;
                r_adr   <= w_word;
            end
        end
    end

    // Next state; the wait counter saturates at WAITSTATES
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_take) begin
            w_state_nxt = w_err ? S_ERR1 : S_WAIT;
            w_cnt_nxt   = '0;
        end else if (w_done) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_last) w_state_nxt = S_RDATA;
                    else        w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
                S_ERR1:  w_state_nxt = S_ERR2;
                default: ;
            endcase
        end
    end

    always_comb begin
        HREADYEXT = 1'b1;
        HRESPEXT  = 1'b0;
        HRDATAEXT = '0;
        MemEn     = 1'b0;
        MemWE     = 1'b0;
        MemWData  = '0;
        MemBE     = '0;
        case (r_state)
            S_WAIT: begin
                HREADYEXT = 1'b0;
                if (w_last) begin
                    MemEn = 1'b1;
                    if (r_write) begin
                        MemWE     = 1'b1;
                        MemWData  = HWDATA;
                        MemBE     = HWSTRB;
                        HREADYEXT = 1'b1;
                    end
                end
            end
            S_RDATA: HRDATAEXT = MemRData;
            S_ERR1: begin
                HRESPEXT  = 1'b1;
                HREADYEXT = 1'b0;
            end
            S_ERR2:  HRESPEXT = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahbext_sram_ctrl.sv
// Bench for ahbext_sram_ctrl: a pipelined AHB master driving directed and random
// transfers, checked per cycle against a transaction-level memory model.
module tb_ahbext_sram_ctrl;

    localparam int unsigned AHBW     = 64;
    localparam int unsigned PA_BITS  = 34;
    localparam int unsigned MEMWORDS = 4096;
    localparam int          WS       = 2;
    localparam logic [33:0] BASE     = 34'h0_9000_0000;
    localparam longint unsigned SPAN = 64'(MEMWORDS) * 64'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        HSELEXT;
    logic [33:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [63:0] HWDATA;
    logic [7:0]  HWSTRB;
    logic [63:0] HRDATAEXT;
    logic        HREADYEXT;
    logic        HRESPEXT;
    logic        MemEn;
    logic        MemWE;
    logic [11:0] MemAdr;
    logic [63:0] MemWData;
    logic [7:0]  MemBE;
    logic [63:0] MemRData = 64'd0;

    assign HREADY = HREADYEXT;

    always #5 clk = ~clk;

    ahbext_sram_ctrl #(
        .AHBW(AHBW), .PA_BITS(PA_BITS), .BASE(BASE),
        .MEMWORDS(MEMWORDS), .WAITSTATES(WS)
    ) dut (
        .clk(clk), .reset(reset), .HSELEXT(HSELEXT), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY),
        .HWDATA(HWDATA), .HWSTRB(HWSTRB), .HRDATAEXT(HRDATAEXT),
        .HREADYEXT(HREADYEXT), .HRESPEXT(HRESPEXT), .MemEn(MemEn),
        .MemWE(MemWE), .MemAdr(MemAdr), .MemWData(MemWData), .MemBE(MemBE),
        .MemRData(MemRData)
    );

    // Synchronous SRAM with registered read data
    logic [63:0] sram [0:MEMWORDS-1];
    initial for (int i = 0; i < int'(MEMWORDS); i++) sram[i] = 64'd0;
    always @(posedge clk) begin
        if (MemEn) begin
            if (MemWE) begin
                for (int b = 0; b < 8; b++)
                    if (MemBE[b]) sram[MemAdr][8*b +: 8] <= MemWData[8*b +: 8];
            end else begin
                MemRData <= sram[MemAdr];
            end
        end
    end

    typedef struct {
        logic [33:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [7:0]  strb;
        int          gap;
    } txn_t;

    txn_t        q[$];
    logic [63:0] ref_mem [int unsigned];
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_err(input txn_t t);
        longint unsigned a;
        a = 64'(t.addr);
        return (a < 64'(BASE)) || ((a - 64'(BASE)) >= SPAN) || (t.size > 3'd3);
    endfunction

    function automatic int unsigned word_of(input txn_t t);
        return 32'((64'(t.addr) - 64'(BASE)) >> 3);
    endfunction

    function automatic logic [63:0] ref_rd(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : 64'd0;
    endfunction

    task automatic add(input logic [33:0] a, input logic wr, input logic [2:0] sz,
                       input logic [63:0] d, input logic [7:0] s, input int gap);
        txn_t t;
        t.addr = a; t.wr = wr; t.size = sz; t.wdata = d; t.strb = s; t.gap = gap;
        q.push_back(t);
    endtask

    // Address phase that must never be accepted
    task automatic idle_phase();
        int s;
        s       = int'($urandom_range(0, 3));
        HSELEXT = (s >= 2);
        HTRANS  = (s == 0) ? 2'b10 : (s == 1) ? 2'b11 : (s == 2) ? 2'b00 : 2'b01;
        HADDR   = BASE + 34'($urandom_range(0, 255));
        HWRITE  = 1'($urandom);
        HSIZE   = 3'd3;
    endtask

    task automatic run_seq();
        int          n;
        int          ap;
        int          dp;
        int          dpc;
        int          gap_left;
        int          budget;
        int          exp_len;
        txn_t        t;
        logic [3:0]  e;
        logic [63:0] erd;
        logic [63:0] d;
        int unsigned w;
        n = q.size(); ap = 0; dp = -1; dpc = 0; budget = 0; exp_len = 0;
        gap_left = (n > 0) ? q[0].gap : 0;
        while ((ap < n || dp >= 0) && budget < 3000) begin
            budget++;
            @(posedge clk); #1;
            if (ap < n && gap_left == 0) begin
                HSELEXT = 1'b1;
                HTRANS  = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
                HADDR   = q[ap].addr;
                HWRITE  = q[ap].wr;
                HSIZE   = q[ap].size;
            end else begin
                idle_phase();
            end
            if (dp >= 0) begin
                HWDATA = q[dp].wdata;
                HWSTRB = q[dp].strb;
            end else begin
                HWDATA = {$urandom, $urandom};
                HWSTRB = 8'($urandom);
            end
            #1;
            if (dp < 0) begin
                chk("idle_ctl", 64'({HREADYEXT, HRESPEXT, MemEn, MemWE}), 64'(4'b1000));
                chk("idle_rdata", HRDATAEXT, 64'd0);
            end else begin
                t = q[dp];
                if (is_err(t)) begin
                    exp_len = 2;
                    e = (dpc == 0) ? 4'b0100 : 4'b1100;
                end else if (t.wr) begin
                    exp_len = WS + 1;
                    e = (dpc == WS) ? 4'b1011 : 4'b0000;
                end else begin
                    exp_len = WS + 2;
                    e = (dpc == WS) ? 4'b0010 : (dpc == WS + 1) ? 4'b1000 : 4'b0000;
                end
                erd = (!is_err(t) && !t.wr && dpc == WS + 1) ? ref_rd(word_of(t)) : 64'd0;
                chk($sformatf("ctl t%0d c%0d", dp, dpc),
                    64'({HREADYEXT, HRESPEXT, MemEn, MemWE}), 64'(e));
                chk($sformatf("rdata t%0d c%0d", dp, dpc), HRDATAEXT, erd);
                if (MemEn && !is_err(t))
                    chk($sformatf("memadr t%0d", dp), 64'(MemAdr), 64'(word_of(t)));
                if (MemWE) begin
                    chk($sformatf("membe t%0d", dp), 64'(MemBE), 64'(t.strb));
                    chk($sformatf("memwdata t%0d", dp), MemWData, t.wdata);
                end
                dpc++;
                if (!HREADYEXT && dpc >= exp_len + 4) begin
                    chk($sformatf("dphase_timeout t%0d", dp), 64'(dpc), 64'(exp_len));
                    dp = -1;
                    ap = n;
                end
            end
            if (HREADYEXT) begin
                if (dp >= 0 && t.wr && !is_err(t)) begin
                    w = word_of(t);
                    d = ref_rd(w);
                    for (int b = 0; b < 8; b++)
                        if (t.strb[b]) d[8*b +: 8] = t.wdata[8*b +: 8];
                    ref_mem[w] = d;
                end
                dp = -1;
                if (ap < n && gap_left == 0) begin
                    dp  = ap;
                    dpc = 0;
                    ap++;
                    gap_left = (ap < n) ? q[ap].gap : 0;
                end else if (gap_left > 0) begin
                    gap_left--;
                end
            end
        end
        if (budget >= 3000) chk("seq_budget", 64'(budget), 64'd0);
        q.delete();
    endtask

    initial begin
        reset = 1'b1; HSELEXT = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
        HSIZE = 3'd0; HWDATA = '0; HWSTRB = '0;
        #12;
        chk("rst_ctl", 64'({HREADYEXT, HRESPEXT, MemEn, MemWE}), 64'(4'b1000));
        chk("rst_rdata", HRDATAEXT, 64'd0);
        chk("rst_be", 64'(MemBE), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Full-word write then read back after idle cycles
        add(BASE + 34'h8, 1'b1, 3'd3, 64'hDEADBEEF_01234567, 8'hFF, 0);
        add(BASE + 34'h8, 1'b0, 3'd3, 64'd0, 8'h00, 2);
        run_seq();

        // Back-to-back pipelined transfers
        add(BASE,          1'b1, 3'd3, 64'h1111_2222_3333_4444, 8'hFF, 1);
        add(BASE + 34'h10, 1'b0, 3'd3, 64'd0, 8'h00, 0);
        add(BASE + 34'h40, 1'b1, 3'd3, 64'hA5A5_5A5A_C3C3_3C3C, 8'hFF, 0);
        add(BASE + 34'h8,  1'b0, 3'd3, 64'd0, 8'h00, 0);
        run_seq();

        // Error responses: past the top, oversize, below the base
        add(BASE + 34'(SPAN), 1'b0, 3'd3,   64'd0, 8'h00, 1);
        add(BASE + 34'h18,    1'b1, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
        add(BASE - 34'h8,     1'b0, 3'd3,   64'd0, 8'h00, 0);
        add(BASE + 34'h18,    1'b0, 3'd3,   64'd0, 8'h00, 0);
        run_seq();

        // Single-byte write merges into the existing word
        add(BASE + 34'h4, 1'b1, 3'd0, 64'h0000_00EE_0000_0000, 8'h10, 1);
        add(BASE,         1'b0, 3'd3, 64'd0, 8'h00, 0);
        run_seq();

        // Reset during the wait states of a write
        @(posedge clk); #1;
        HSELEXT = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd3; HADDR = BASE + 34'h40;
        @(posedge clk); #1;
        HSELEXT = 1'b0; HTRANS = 2'b00; HWDATA = 64'h0BAD_0BAD_0BAD_0BAD; HWSTRB = 8'hFF;
        @(posedge clk); #1;
        #1;
        chk("rst_pre_ctl", 64'({HREADYEXT, HRESPEXT, MemEn, MemWE}), 64'(4'b0000));
        reset = 1'b1;
        #1;
        chk("rst_async_ctl", 64'({HREADYEXT, HRESPEXT, MemEn, MemWE}), 64'(4'b1000));
        chk("rst_async_be", 64'(MemBE), 64'd0);
        @(posedge clk); #1;
        chk("rst_hold_we", 64'(MemWE), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        add(BASE + 34'h40, 1'b0, 3'd3, 64'd0, 8'h00, 0);
        add(BASE + 34'h48, 1'b1, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
        add(BASE + 34'h48, 1'b0, 3'd3, 64'd0, 8'h00, 0);
        run_seq();

        // Randomized traffic including boundary and illegal addresses
        for (int i = 0; i < 150; i++) begin
            int          sel;
            logic [33:0] a;
            logic [2:0]  sz;
            int          g;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       a = BASE - 34'(8 * $urandom_range(1, 4));
                1:       a = BASE + 34'(SPAN) + 34'(8 * $urandom_range(0, 3));
                2:       a = BASE + 34'(SPAN - 64'd8);
                default: a = BASE + 34'($urandom_range(0, 255));
            endcase
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            add(a, 1'($urandom), sz, {$urandom, $urandom}, 8'($urandom), g);
        end
        run_seq();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
